demux_1to2: RTL and testbench



---
 rtl/demux_1to2.sv | 44 ++++
 tb/tb_demux_1to2.sv | 124 ++++++++++++
 2 files changed

// File: rtl/demux_1to2.sv
// demux_1to2: registered 1-to-2 demultiplexer.
// The input word is steered to y0 (sel=0) or y1 (sel=1) on each rising
// clock edge. The unselected output is driven to all-zeros, so at most one
// output is ever non-zero. Both outputs come straight from flops, so there
// is no combinational path from in/sel to y0/y1 and exactly one cycle of
// latency. rst is synchronous and active-high and overrides routing.
module demux_1to2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             sel,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1
);

  logic [WIDTH-1:0] r_y0;
  logic [WIDTH-1:0] r_y1;
  logic [WIDTH-1:0] w_y0_next;
  logic [WIDTH-1:0] w_y1_next;

  // Next-state steering: each data bit goes to exactly one route, the other
  // route's copy of that bit is forced low.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign w_y0_next[gi] = in[gi] & ~sel;
    assign w_y1_next[gi] = in[gi] &  sel;
  end

  // Output registers: reset clears both routes, otherwise load the steered word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y0 <= '0;
      r_y1 <= '0;
    end else begin
      r_y0 <= w_y0_next;
      r_y1 <= w_y1_next;
    end
  end

  assign y0 = r_y0;
  assign y1 = r_y1;

endmodule

// File: tb/tb_demux_1to2.sv
// Directed testbench for demux_1to2 (WIDTH=4): a vector table for
// edge-by-edge routing/reset behaviour plus hand-written sequences for
// mid-cycle select changes and one-cycle latency.
module tb_demux_1to2;

  localparam int W = 4;
  localparam int NVEC = 15;

  logic         clk;
  logic         rst;
  logic [W-1:0] in;
  logic         sel;
  logic [W-1:0] y0;
  logic [W-1:0] y1;

  int checks;
  int failures;

  typedef struct {
    logic         rst;
    logic [W-1:0] in;
    logic         sel;
    logic [W-1:0] exp_y0;
    logic [W-1:0] exp_y1;
  } vec_t;

  vec_t vecs [NVEC];

  demux_1to2 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .sel (sel),
    .y0  (y0),
    .y1  (y1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;

    //            rst   in     sel   y0     y1
    vecs[0]  = '{1'b1, 4'h1, 1'b1, 4'h0, 4'h0}; // reset with in=1 sel=1
    vecs[1]  = '{1'b1, 4'hF, 1'b0, 4'h0, 4'h0}; // reset with in=F sel=0
    vecs[2]  = '{1'b0, 4'h1, 1'b0, 4'h1, 4'h0}; // route 0
    vecs[3]  = '{1'b0, 4'h1, 1'b1, 4'h0, 4'h1}; // route 1
    vecs[4]  = '{1'b0, 4'h0, 1'b0, 4'h0, 4'h0}; // zero data, sel 0
    vecs[5]  = '{1'b0, 4'h0, 1'b1, 4'h0, 4'h0}; // zero data, sel 1
    vecs[6]  = '{1'b0, 4'hA, 1'b0, 4'hA, 4'h0}; // bit pattern to y0
    vecs[7]  = '{1'b0, 4'h5, 1'b1, 4'h0, 4'h5}; // in and sel change together
    vecs[8]  = '{1'b0, 4'hF, 1'b1, 4'h0, 4'hF}; // all ones to y1
    vecs[9]  = '{1'b0, 4'h1, 1'b1, 4'h0, 4'h1}; // y1=1 before mid-stream reset
    vecs[10] = '{1'b1, 4'h1, 1'b1, 4'h0, 4'h0}; // mid-stream reset
    vecs[11] = '{1'b0, 4'h1, 1'b1, 4'h0, 4'h1}; // resume after reset
    vecs[12] = '{1'b0, 4'h8, 1'b0, 4'h8, 4'h0}; // MSB to y0
    vecs[13] = '{1'b1, 4'h8, 1'b0, 4'h0, 4'h0}; // reset beats routing
    vecs[14] = '{1'b0, 4'h3, 1'b0, 4'h3, 4'h0}; // resume on route 0

    rst = 1'b1;
    in  = '0;
    sel = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      rst = vecs[i].rst;
      in  = vecs[i].in;
      sel = vecs[i].sel;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_y0", i), y0, vecs[i].exp_y0);
      check($sformatf("vec%0d_y1", i), y1, vecs[i].exp_y1);
      $display("vec%0d rst=%b in=%h sel=%b -> y0=%h y1=%h", i, rst, in, sel, y0, y1);
    end

    // Route 5 to y1, then glitch sel mid-cycle and restore it before the edge.
    rst = 1'b0;
    in  = 4'h5;
    sel = 1'b1;
    @(posedge clk);
    #1;
    check("glitch_setup_y1", y1, 4'h5);
    #1 sel = 1'b0;
    #2;
    check("glitch_mid_y0", y0, 4'h0);
    check("glitch_mid_y1", y1, 4'h5);
    #1 sel = 1'b1;
    @(posedge clk);
    #1;
    check("glitch_after_y0", y0, 4'h0);
    check("glitch_after_y1", y1, 4'h5);
    $display("glitch seq: y0=%h y1=%h", y0, y1);

    // Latency: a new select/data pair is invisible until the next edge.
    in  = 4'h6;
    sel = 1'b0;
    #2;
    check("lat_pre_y0", y0, 4'h0);
    check("lat_pre_y1", y1, 4'h5);
    @(posedge clk);
    #1;
    check("lat_post_y0", y0, 4'h6);
    check("lat_post_y1", y1, 4'h0);
    $display("latency seq: y0=%h y1=%h", y0, y1);

    // Hold: with inputs stable, outputs keep their value across idle time.
    #3;
    check("hold_y0", y0, 4'h6);
    check("hold_y1", y1, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
